// File: rtl/frame_assembler.sv
// Frame assembler: shifts ROW_W-bit rows into a NUM_ROWS-row frame buffer and holds it until acknowledged.
// Optional macro FRAME_AUTO_RESTART_EN: an acknowledged frame immediately re-enters capture instead of idling.
module frame_assembler #(
  parameter int ROW_W    = 7,
  parameter int NUM_ROWS = 28
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             row_valid,
  input  logic [ROW_W-1:0]                 row_data,
  output logic                             row_ready,
  output logic [ROW_W*NUM_ROWS-1:0]        frame_data,
  output logic                             frame_valid,
  input  logic                             frame_ack,
  output logic [$clog2(NUM_ROWS+1)-1:0]    row_count,
  output logic [7:0]                       frame_count
);

  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam int FW    = ROW_W * NUM_ROWS;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

`ifdef FRAME_AUTO_RESTART_EN
  localparam logic AUTO_RESTART = 1'b1;
`else
  localparam logic AUTO_RESTART = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   clr_buf;
  logic   row_xfer;
  logic   frame_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A start during capture wins over a same-cycle row, so the row is dropped.
  always_comb begin
    state_nxt  = state;
    clr_buf    = 1'b0;
    row_xfer   = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CAPTURE;
          clr_buf   = 1'b1;
        end
      end
      CAPTURE: begin
        if (start) begin
          clr_buf = 1'b1;
        end else if (row_valid) begin
          row_xfer = 1'b1;
          if (row_count == LAST_ROW) begin
            frame_done = 1'b1;
            state_nxt  = HOLD;
          end
        end
      end
      HOLD: begin
        if (frame_ack) begin
          if (start || AUTO_RESTART) begin
            state_nxt = CAPTURE;
            clr_buf   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign row_ready   = (state == CAPTURE);
  assign frame_valid = (state == HOLD);

  // Newest row enters at the LSBs, so the first row of a frame ends in the MSBs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data <= '0;
      row_count  <= '0;
    end else if (clr_buf) begin
      frame_data <= '0;
      row_count  <= '0;
    end else if (row_xfer) begin
      frame_data <= {frame_data[FW-ROW_W-1:0], row_data};
      row_count  <= row_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           frame_count <= 8'd0;
    else if (frame_done) frame_count <= frame_count + 8'd1;
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler: random rows checked against a queue-based frame model.
module tb_frame_assembler;
  localparam int ROW_W    = 7;
  localparam int NUM_ROWS = 28;
  localparam int FW       = ROW_W * NUM_ROWS;
  localparam int CNT_W    = $clog2(NUM_ROWS + 1);
`ifdef FRAME_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             row_valid = 1'b0;
  logic [ROW_W-1:0] row_data = '0;
  logic             row_ready;
  logic [FW-1:0]    frame_data;
  logic             frame_valid;
  logic             frame_ack = 1'b0;
  logic [CNT_W-1:0] row_count;
  logic [7:0]       frame_count;

  int checks = 0;
  int errors = 0;

  // Reference model: rows accepted so far, completed-frame count and phase.
  logic [ROW_W-1:0] m_rows[$];
  int               m_frames = 0;
  int               m_phase = 0;   // 0 idle, 1 capturing, 2 holding

  frame_assembler #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS)) dut (
    .clk(clk), .reset(reset), .start(start), .row_valid(row_valid),
    .row_data(row_data), .row_ready(row_ready), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .row_count(row_count),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] exp_frame();
    logic [FW-1:0] f;
    int n;
    f = '0;
    n = m_rows.size();
    for (int i = 0; i < n; i++) f[(n-1-i)*ROW_W +: ROW_W] = m_rows[i];
    return f;
  endfunction

  task automatic model_reset();
    m_rows.delete();
    m_frames = 0;
    m_phase  = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (start) begin m_rows.delete(); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (start) m_rows.delete();
      else if (row_valid) begin
        m_rows.push_back(row_data);
        if (m_rows.size() == NUM_ROWS) begin
          m_phase  = 2;
          m_frames = (m_frames + 1) % 256;
        end
      end
    end else if (frame_ack) begin
      if (start || AUTO) begin m_rows.delete(); m_phase = 1; end
      else m_phase = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; row_valid = 0; frame_ack = 0; row_data = '0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    #3;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%0b exp=0", frame_valid); end
    checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL reset_rr got=%0b exp=0", row_ready); end
    checks++; if (row_count !== '0 || frame_count !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", row_count, frame_count); end
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", frame_data); end
    step(); step();
    reset = 0; model_reset();
    row_valid = 1; frame_ack = 1;
    for (int i = 0; i < 5; i++) begin
      row_data = ROW_W'($urandom);
      step();
      checks++; if (row_ready !== 1'b0 || row_count !== '0) begin errors++; $display("FAIL idle_ignore rr=%0b rc=%0d exp=0/0", row_ready, row_count); end
    end
    idle_inputs();
  endtask

  task automatic test_basic();
    start = 1; step(); start = 0;
    checks++; if (row_ready !== 1'b1) begin errors++; $display("FAIL start_rr got=%0b exp=1", row_ready); end
    row_valid = 1;
    for (int r = 1; r <= NUM_ROWS; r++) begin
      row_data = ROW_W'(r);
      step();
      checks++; if (frame_valid !== (r == NUM_ROWS)) begin errors++; $display("FAIL basic_fv row=%0d got=%0b exp=%0b", r, frame_valid, r == NUM_ROWS); end
    end
    row_valid = 0;
    checks++; if (frame_data[195:189] !== 7'h01) begin errors++; $display("FAIL basic_msb got=%h exp=01", frame_data[195:189]); end
    checks++; if (frame_data[6:0] !== 7'h1C) begin errors++; $display("FAIL basic_lsb got=%h exp=1c", frame_data[6:0]); end
    checks++; if (frame_count !== 8'd1 || row_count !== CNT_W'(NUM_ROWS)) begin errors++; $display("FAIL basic_cnt got=%0d/%0d exp=1/28", frame_count, row_count); end
    checks++; if (frame_data !== exp_frame()) begin errors++; $display("FAIL basic_frame got=%h exp=%h", frame_data, exp_frame()); end
    frame_ack = 1; step(); frame_ack = 0;
    checks++; if (frame_valid !== 1'b0 || row_ready !== (m_phase == 1)) begin errors++; $display("FAIL basic_ack fv=%0b rr=%0b", frame_valid, row_ready); end
    checks++; if (frame_data !== exp_frame()) begin errors++; $display("FAIL basic_retain got=%h exp=%h", frame_data, exp_frame()); end
  endtask

  task automatic test_toggle();
    int cycles;
    reset = 1; #2; reset = 0; model_reset(); idle_inputs();
    start = 1; step(); start = 0;
    cycles = 0;
    while (m_phase == 1 && cycles < 500) begin
      row_valid = (cycles % 2 == 0);
      row_data  = ROW_W'($urandom);
      step();
      cycles++;
      checks++; if (row_count !== CNT_W'(m_rows.size())) begin errors++; $display("FAIL toggle_rc got=%0d exp=%0d", row_count, m_rows.size()); end
    end
    row_valid = 0;
    checks++; if (m_phase != 2 || frame_valid !== 1'b1) begin errors++; $display("FAIL toggle_done fv=%0b exp=1", frame_valid); end
    checks++; if (frame_data !== exp_frame()) begin errors++; $display("FAIL toggle_frame got=%h exp=%h", frame_data, exp_frame()); end
    frame_ack = 1; step(); frame_ack = 0;
  endtask

  task automatic test_restart();
    idle_inputs();
    start = 1; step(); start = 0;
    row_valid = 1;
    for (int i = 0; i < 10; i++) begin row_data = ROW_W'($urandom); step(); end
    start = 1; row_data = 7'h7F; step(); start = 0;
    checks++; if (row_count !== '0 || frame_data !== '0) begin errors++; $display("FAIL restart_clr rc=%0d data=%h exp=0", row_count, frame_data); end
    for (int i = 0; i < NUM_ROWS; i++) begin row_data = ROW_W'($urandom); step(); end
    row_valid = 0;
    checks++; if (frame_valid !== 1'b1 || frame_data !== exp_frame()) begin errors++; $display("FAIL restart_frame got=%h exp=%h", frame_data, exp_frame()); end
    checks++; if (frame_count !== 8'(m_frames)) begin errors++; $display("FAIL restart_fc got=%0d exp=%0d", frame_count, m_frames); end
  endtask

  task automatic test_hold();
    logic [FW-1:0] held;
    int bad;
    held = frame_data;
    bad = 0;
    row_valid = 1;
    for (int i = 0; i < 50; i++) begin
      row_data = ROW_W'($urandom);
      start    = (i % 7 == 3);
      step();
      if (frame_data !== held || row_ready !== 1'b0 || frame_valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
    start = 0; row_valid = 0; frame_ack = 1; step(); frame_ack = 0;
    checks++; if (frame_valid !== 1'b0 || row_ready !== (m_phase == 1)) begin errors++; $display("FAIL hold_ack fv=%0b rr=%0b", frame_valid, row_ready); end
    checks++; if (frame_data !== exp_frame()) begin errors++; $display("FAIL hold_retain got=%h exp=%h", frame_data, exp_frame()); end
    if (m_phase == 1) begin start = 1; step(); start = 0; end
  endtask

  task automatic test_reset_mid();
    int early;
    idle_inputs();
    start = 1; step(); start = 0;
    row_valid = 1;
    for (int i = 0; i < 20; i++) begin row_data = ROW_W'($urandom); step(); end
    #2 reset = 1; model_reset();
    #1;
    checks++; if (row_count !== '0 || frame_count !== 8'd0 || frame_data !== '0 || row_ready !== 1'b0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL midreset rc=%0d fc=%0d rr=%0b fv=%0b", row_count, frame_count, row_ready, frame_valid); end
    step(); reset = 0;
    early = 0;
    for (int i = 0; i < 20; i++) begin row_data = ROW_W'($urandom); step(); if (frame_valid !== 1'b0) early++; end
    start = 1; step(); start = 0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_data = ROW_W'($urandom); step();
      if (frame_valid !== (i == NUM_ROWS - 1)) early++;
    end
    row_valid = 0;
    checks++; if (early != 0) begin errors++; $display("FAIL midreset_fv bad_cycles=%0d exp=0", early); end
    checks++; if (frame_data !== exp_frame() || frame_count !== 8'd1) begin errors++; $display("FAIL midreset_frame fc=%0d exp=1", frame_count); end
    frame_ack = 1; step(); frame_ack = 0;
  endtask

  task automatic test_back_to_back();
    int bad;
    reset = 1; #2; reset = 0; model_reset(); idle_inputs();
    bad = 0;
    start = 1; step(); start = 0;
    for (int f = 0; f < 256; f++) begin
      row_valid = 1;
      for (int r = 0; r < NUM_ROWS; r++) begin row_data = ROW_W'($urandom); step(); end
      row_valid = 0;
      if (frame_valid !== 1'b1 || frame_data !== exp_frame() || frame_count !== 8'(m_frames)) bad++;
      if (f == 254) begin
        checks++; if (frame_count !== 8'd255) begin errors++; $display("FAIL b2b_fc255 got=%0d exp=255", frame_count); end
      end
      frame_ack = 1; start = !AUTO; step(); frame_ack = 0; start = 0;
      if (row_ready !== 1'b1 || frame_valid !== 1'b0 || row_count !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frames bad=%0d exp=0", bad); end
    checks++; if (frame_count !== 8'd0 || m_frames != 0) begin errors++; $display("FAIL b2b_wrap got=%0d exp=0", frame_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_restart();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/frame_assembler.md
FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 SHALL have parameter ROW_W, default 7: bits per row word.
REQ-002 SHALL have parameter NUM_ROWS, default 28: rows per frame, legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a new frame capture.
REQ-006 SHALL have port row_valid, input, 1 bit: row_data is valid this cycle.
REQ-007 SHALL have port row_data, input, ROW_W bits: one row of pixel bits.
REQ-008 SHALL have port row_ready, output, 1 bit: block accepts a row this cycle.
REQ-009 SHALL have port frame_data, output, ROW_W*NUM_ROWS bits: the assembled frame.
REQ-010 SHALL have port frame_valid, output, 1 bit: frame_data holds a complete frame.
REQ-011 SHALL have port frame_ack, input, 1 bit: consumer has taken the frame.
REQ-012 SHALL have port row_count, output, $clog2(NUM_ROWS+1) bits: rows accepted in the current frame.
REQ-013 SHALL have port frame_count, output, 8 bits: completed frames since reset.

Function
REQ-014 SHALL implement three states: IDLE, CAPTURE and HOLD.
REQ-015 IDLE: start=1 SHALL move to CAPTURE next cycle, clearing frame_data and row_count to 0.
REQ-016 row_ready SHALL be 1 only in CAPTURE, decoded combinationally from state.
REQ-017 A row transfer SHALL occur only when row_valid && row_ready; row_valid in any other state SHALL be ignored.
REQ-018 Each transfer SHALL do frame_data <= {frame_data[ROW_W*(NUM_ROWS-1)-1:0], row_data} and row_count <= row_count+1, so the first row ends in the MSBs.
REQ-019 The NUM_ROWS-th transfer SHALL, in the next cycle, give state HOLD, frame_valid=1, row_count=NUM_ROWS, and frame_count+1 (wrapping 255->0).
REQ-020 In HOLD, frame_valid and frame_data SHALL remain stable until frame_ack=1 is sampled.
REQ-021 HOLD with frame_ack=1 and start=0 SHALL go to IDLE, with frame_valid=0 next cycle and frame_data retained.
REQ-022 HOLD with frame_ack=1 and start=1 SHALL go directly to CAPTURE with a cleared buffer.
REQ-023 HOLD with start=1 and frame_ack=0 SHALL ignore start.
REQ-024 frame_ack SHALL be ignored outside HOLD.
REQ-025 start=1 in CAPTURE SHALL restart the capture: buffer and row_count cleared, any row transfer in that same cycle discarded, frame_count unchanged.
REQ-026 Latency from the last row transfer to frame_valid SHALL be exactly 1 cycle.
REQ-027 Row throughput SHALL be one row per cycle while row_valid is held high.

Reset
REQ-028 reset=1 SHALL immediately force: state IDLE, frame_data 0, frame_valid 0, row_count 0, frame_count 0; row_ready is therefore 0.
REQ-029 Reset asserted mid-CAPTURE or mid-HOLD SHALL discard the partial or held frame; no frame_valid pulse SHALL follow release.
REQ-030 After reset deasserts, the first state change SHALL occur on the first clk edge with start=1.

Configuration
REQ-031 Macro FRAME_AUTO_RESTART_EN SHALL control automatic restart of capture.
REQ-032 With FRAME_AUTO_RESTART_EN defined, the HOLD-to-IDLE transition of REQ-021 SHALL instead go to CAPTURE with a cleared buffer, as if start were asserted.
REQ-033 Without FRAME_AUTO_RESTART_EN, the block SHALL behave exactly as REQ-014..REQ-027.

Verification
REQ-034 Defaults; reset; start; 28 rows 7'h01..7'h1C with row_valid held -> frame_valid 1 cycle after the last row; frame_data[195:189]=7'h01; frame_data[6:0]=7'h1C; frame_count=1.
REQ-035 row_valid toggling 1/0 during capture -> exactly 28 transfers accepted; row_count steps 0..28 only on transfer cycles.
REQ-036 start asserted after 10 rows -> row_count=0 next cycle; 28 further rows produce one frame with no trace of the first 10 rows.
REQ-037 frame_valid held 50 cycles with frame_ack=0 while row_valid=1 and start pulses -> frame_data unchanged; row_ready=0; frame_ack then -> IDLE with frame_valid=0.
REQ-038 reset pulsed after 20 rows -> all outputs 0 immediately; no frame_valid until a new start plus 28 rows.
REQ-039 FRAME_AUTO_RESTART_EN defined; 256 back-to-back frames, each acked -> row_ready returns 1 cycle after each ack; frame_count wraps to 0.
